// File: rtl/nvme_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// nvme_buffer_arbiter
//
// This block shares the NVMe data buffer RAM between two DMA requesters.
// Requester 0 is the PCIe completion path and requester 1 is the host AXI path.
//
// Write port:
//   - Round-robin arbitration between w0 and w1.
//   - A multi-beat burst locks the port to its owner until the beat with
//     last=1 is accepted.
//   - A handshake drives the RAM write in the same cycle.
//
// Read port:
//   - Round-robin arbitration between r0 and r1, one beat per grant, no lock.
//   - The RAM registers its read data. A one-bit tag routes that data back
//     to the requester that issued the read, one cycle later.
//
// Ports:
//   clk, rst_n                 sole clock; asynchronous active-low reset
//   i_wN_valid / o_wN_ready    write handshake (N = 0, 1)
//   i_wN_addr/_be/_data/_last  write word address, 32-bit lane enables,
//                              data, burst-end flag
//   i_rN_valid / o_rN_ready    read handshake (N = 0, 1)
//   i_rN_addr                  read word address
//   o_rN_rvalid / o_rN_rdata   read response, one cycle after handshake
//   o_ram_we/_waddr/_din       RAM write port (per-lane enables)
//   o_ram_re/_raddr            RAM read port
//   i_ram_dout                 RAM read data, valid the cycle after o_ram_re
// ---------------------------------------------------------------------------
module nvme_buffer_arbiter #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // write requester 0
  input  logic                 i_w0_valid,
  output logic                 o_w0_ready,
  input  logic [ADDR_BITS-1:0] i_w0_addr,
  input  logic [3:0]           i_w0_be,
  input  logic [127:0]         i_w0_data,
  input  logic                 i_w0_last,
  // write requester 1
  input  logic                 i_w1_valid,
  output logic                 o_w1_ready,
  input  logic [ADDR_BITS-1:0] i_w1_addr,
  input  logic [3:0]           i_w1_be,
  input  logic [127:0]         i_w1_data,
  input  logic                 i_w1_last,
  // read requester 0
  input  logic                 i_r0_valid,
  output logic                 o_r0_ready,
  input  logic [ADDR_BITS-1:0] i_r0_addr,
  output logic                 o_r0_rvalid,
  output logic [127:0]         o_r0_rdata,
  // read requester 1
  input  logic                 i_r1_valid,
  output logic                 o_r1_ready,
  input  logic [ADDR_BITS-1:0] i_r1_addr,
  output logic                 o_r1_rvalid,
  output logic [127:0]         o_r1_rdata,
  // buffer RAM
  output logic [3:0]           o_ram_we,
  output logic [ADDR_BITS-1:0] o_ram_waddr,
  output logic [127:0]         o_ram_din,
  output logic                 o_ram_re,
  output logic [ADDR_BITS-1:0] o_ram_raddr,
  input  logic [127:0]         i_ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } wstate_e;

  wstate_e r_wstate;
  logic    r_wlast_gnt;   // last requester granted a write beat
  logic    r_rlast_gnt;   // last requester granted a read
  logic    r_tag_valid;   // a read was accepted last cycle
  logic    r_tag_id;      // which requester issued that read

  logic    w_wgnt0;
  logic    w_wgnt1;
  logic    w_rgnt0;
  logic    w_rgnt1;

  // -------------------------------------------------------------------------
  // Write grant.
  // Grants are forced low while reset is asserted, so no handshake and no
  // RAM write can happen during reset.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_wgnt0 = 1'b0;
    w_wgnt1 = 1'b0;
    if (rst_n) begin
      case (r_wstate)
        ST_IDLE: begin
          // On contention, the requester that did not win last time wins.
          w_wgnt0 = i_w0_valid && (!i_w1_valid ||  r_wlast_gnt);
          w_wgnt1 = i_w1_valid && (!i_w0_valid || !r_wlast_gnt);
        end
        ST_LOCK0: w_wgnt0 = i_w0_valid;
        ST_LOCK1: w_wgnt1 = i_w1_valid;
        default: ;
      endcase
    end
  end

  assign o_w0_ready  = w_wgnt0;
  assign o_w1_ready  = w_wgnt1;
  assign o_ram_we    = w_wgnt0 ? i_w0_be : (w_wgnt1 ? i_w1_be : 4'b0000);
  assign o_ram_waddr = w_wgnt1 ? i_w1_addr : i_w0_addr;
  assign o_ram_din   = w_wgnt1 ? i_w1_data : i_w0_data;

  // -------------------------------------------------------------------------
  // Write burst lock FSM.
  // A beat with be=0 still counts as a beat, so its last bit is honoured.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate    <= ST_IDLE;
      r_wlast_gnt <= 1'b1;   // requester 0 wins the first contention
    end else if (w_wgnt0) begin
      // NOTE: state is updated with non-blocking assignments, so every
      // right-hand side sees the values from before this clock edge.
      r_wlast_gnt <= 1'b0;
      r_wstate    <= i_w0_last ? ST_IDLE : ST_LOCK0;
    end else if (w_wgnt1) begin
      r_wlast_gnt <= 1'b1;
      r_wstate    <= i_w1_last ? ST_IDLE : ST_LOCK1;
    end
  end

  // -------------------------------------------------------------------------
  // Read arbitration: single beat, round-robin, never locks.
  // -------------------------------------------------------------------------
  assign w_rgnt0 = rst_n && i_r0_valid && (!i_r1_valid ||  r_rlast_gnt);
  assign w_rgnt1 = rst_n && i_r1_valid && (!i_r0_valid || !r_rlast_gnt);

  assign o_r0_ready  = w_rgnt0;
  assign o_r1_ready  = w_rgnt1;
  assign o_ram_re    = w_rgnt0 || w_rgnt1;
  assign o_ram_raddr = w_rgnt1 ? i_r1_addr : i_r0_addr;

  // The tag follows the RAM's one-cycle read pipeline.
  // Reset clears it, so a response that is still in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rlast_gnt <= 1'b1;
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
    end else begin
      r_tag_valid <= w_rgnt0 || w_rgnt1;
      r_tag_id    <= w_rgnt1;
      if (w_rgnt0) begin
        r_rlast_gnt <= 1'b0;
      end else if (w_rgnt1) begin
        r_rlast_gnt <= 1'b1;
      end
    end
  end

  assign o_r0_rvalid = r_tag_valid && !r_tag_id;
  assign o_r1_rvalid = r_tag_valid &&  r_tag_id;
  // Both requesters see the RAM data; only rvalid says whose it is.
  assign o_r0_rdata  = i_ram_dout;
  assign o_r1_rdata  = i_ram_dout;

endmodule

// File: tb/tb_nvme_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nvme_buffer_arbiter
//
// Self-checking bench for nvme_buffer_arbiter.
//   - A behavioural buffer RAM is attached to the DUT's RAM port.
//   - A reference model tracks the expected grants, the burst owner and the
//     expected memory contents. It works at the level of "which requester
//     owns the port" and a plain word array.
//   - Stimulus comes from three sources: a vector table, hand-written
//     corner-case sequences, and random traffic.
// ---------------------------------------------------------------------------
module tb_nvme_buffer_arbiter;

  localparam int AB    = 8;
  localparam int WORDS = 1 << AB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // requester-side stimulus, indexed by requester number
  logic          w_valid [2];
  logic [AB-1:0] w_addr  [2];
  logic [3:0]    w_be    [2];
  logic [127:0]  w_data  [2];
  logic          w_last  [2];
  logic          r_valid [2];
  logic [AB-1:0] r_addr  [2];

  logic          w0_ready, w1_ready, r0_ready, r1_ready;
  logic          r0_rvalid, r1_rvalid;
  logic [127:0]  r0_rdata, r1_rdata;
  logic [3:0]    ram_we;
  logic [AB-1:0] ram_waddr, ram_raddr;
  logic [127:0]  ram_din, ram_dout;
  logic          ram_re;

  nvme_buffer_arbiter #(.ADDR_BITS(AB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_w0_valid  (w_valid[0]),
    .o_w0_ready  (w0_ready),
    .i_w0_addr   (w_addr[0]),
    .i_w0_be     (w_be[0]),
    .i_w0_data   (w_data[0]),
    .i_w0_last   (w_last[0]),
    .i_w1_valid  (w_valid[1]),
    .o_w1_ready  (w1_ready),
    .i_w1_addr   (w_addr[1]),
    .i_w1_be     (w_be[1]),
    .i_w1_data   (w_data[1]),
    .i_w1_last   (w_last[1]),
    .i_r0_valid  (r_valid[0]),
    .o_r0_ready  (r0_ready),
    .i_r0_addr   (r_addr[0]),
    .o_r0_rvalid (r0_rvalid),
    .o_r0_rdata  (r0_rdata),
    .i_r1_valid  (r_valid[1]),
    .o_r1_ready  (r1_ready),
    .i_r1_addr   (r_addr[1]),
    .o_r1_rvalid (r1_rvalid),
    .o_r1_rdata  (r1_rdata),
    .o_ram_we    (ram_we),
    .o_ram_waddr (ram_waddr),
    .o_ram_din   (ram_din),
    .o_ram_re    (ram_re),
    .o_ram_raddr (ram_raddr),
    .i_ram_dout  (ram_dout)
  );

  // Replace the 32-bit lanes of old_w selected by be with the lanes of new_w.
  function automatic logic [127:0] lane_merge(input logic [127:0] old_w,
                                              input logic [127:0] new_w,
                                              input logic [3:0]   be);
    lane_merge = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) lane_merge[32*i +: 32] = new_w[32*i +: 32];
  endfunction

  // Behavioural buffer RAM. The read is registered and returns the data from
  // before any write that happens at the same edge.
  logic [127:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (ram_re) ram_dout <= ram_mem[ram_raddr];
    if (|ram_we) ram_mem[ram_waddr] <= lane_merge(ram_mem[ram_waddr], ram_din, ram_we);
  end

  // ---------------- reference model ----------------
  logic [127:0] ref_mem [WORDS];
  int           lock_owner;        // -1: port free, else owning writer
  int           last_w, last_r;    // requester that won last time
  int           pend_rv;           // -1: no response due, else reader id
  logic [127:0] pend_data;
  bit           acc_w [2];
  bit           acc_r [2];
  int           comp_starts [2];   // competing bursts begun while waiting
  int           wait_cyc [2];
  int           max_wait;
  int           beats_left [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_owner = -1;
    last_w     = 1;
    last_r     = 1;
    pend_rv    = -1;
    for (int n = 0; n < 2; n++) begin
      comp_starts[n] = 0;
      wait_cyc[n]    = 0;
      acc_w[n]       = 1'b0;
      acc_r[n]       = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      w_valid[n] = 1'b0;
      w_addr[n]  = '0;
      w_be[n]    = 4'h0;
      w_data[n]  = '0;
      w_last[n]  = 1'b1;
      r_valid[n] = 1'b0;
      r_addr[n]  = '0;
    end
  endtask

  // Called right after inputs are set at a falling edge.
  //   1. Compares DUT outputs with the model.
  //   2. Advances the model by one clock.
  //   3. Returns at the next falling edge.
  task automatic run_cycle();
    int         wg;
    int         rg;
    logic [3:0] exp_we;
    #1;
    // response to the read accepted in the previous cycle
    check1("r0_rvalid", r0_rvalid, pend_rv == 0);
    check1("r1_rvalid", r1_rvalid, pend_rv == 1);
    if (pend_rv == 0) check128("r0_rdata", r0_rdata, pend_data);
    if (pend_rv == 1) check128("r1_rdata", r1_rdata, pend_data);

    // Write port: the burst owner, if any, is the only candidate.
    // Otherwise, on contention, the requester that did not win last time wins.
    wg = -1;
    if (lock_owner >= 0) begin
      if (w_valid[lock_owner]) wg = lock_owner;
    end else if (w_valid[0] && w_valid[1]) begin
      wg = 1 - last_w;
    end else if (w_valid[0]) begin
      wg = 0;
    end else if (w_valid[1]) begin
      wg = 1;
    end
    check1("w0_ready", w0_ready, wg == 0);
    check1("w1_ready", w1_ready, wg == 1);
    exp_we = (wg >= 0) ? w_be[wg] : 4'b0000;
    check128("ram_we", 128'(ram_we), 128'(exp_we));
    if (wg >= 0) begin
      check128("ram_waddr", 128'(ram_waddr), 128'(w_addr[wg]));
      check128("ram_din", ram_din, w_data[wg]);
    end

    // Read port: plain round-robin.
    rg = -1;
    if (r_valid[0] && r_valid[1]) rg = 1 - last_r;
    else if (r_valid[0])          rg = 0;
    else if (r_valid[1])          rg = 1;
    check1("r0_ready", r0_ready, rg == 0);
    check1("r1_ready", r1_ready, rg == 1);
    check1("ram_re", ram_re, rg >= 0);
    if (rg >= 0) check128("ram_raddr", 128'(ram_raddr), 128'(r_addr[rg]));

    // Fairness: a waiting writer sees at most one competing burst begin.
    for (int n = 0; n < 2; n++) begin
      if (w_valid[n] && wg != n) begin
        wait_cyc[n]++;
        if (wg == 1 - n && lock_owner < 0) comp_starts[n]++;
      end
      if (wg == n) begin
        check1("w_wait_one_burst", comp_starts[n] <= 1, 1'b1);
        if (wait_cyc[n] > max_wait) max_wait = wait_cyc[n];
        comp_starts[n] = 0;
        wait_cyc[n]    = 0;
      end
    end

    // Advance the model. The read captures pre-write data.
    pend_rv = rg;
    if (rg >= 0) begin
      pend_data = ref_mem[r_addr[rg]];
      last_r    = rg;
    end
    if (wg >= 0) begin
      ref_mem[w_addr[wg]] = lane_merge(ref_mem[w_addr[wg]], w_data[wg], w_be[wg]);
      last_w     = wg;
      lock_owner = w_last[wg] ? -1 : wg;
    end
    for (int n = 0; n < 2; n++) begin
      acc_w[n] = (wg == n);
      acc_r[n] = (rg == n);
    end
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  // Bit 0 of each 2-bit field is requester 0; bit 1 is requester 1.
  typedef struct {
    logic [1:0] wv;      // write valids
    logic [1:0] wl;      // write last flags
    logic [3:0] be0;
    logic [3:0] be1;
    logic [1:0] rv;      // read valids
    logic [1:0] exp_wr;  // expected write readys
    logic [3:0] exp_we;
    logic [1:0] exp_rr;  // expected read readys
    logic [1:0] exp_rv;  // expected rvalids (from the previous row's read)
  } vec_t;

  vec_t tbl [10];

  initial begin
    // alternating contention from reset: grants 0,1,0,1 on both ports
    tbl[0] = '{2'b11, 2'b11, 4'h1, 4'h2, 2'b11, 2'b01, 4'h1, 2'b01, 2'b00};
    tbl[1] = '{2'b11, 2'b11, 4'h1, 4'h2, 2'b11, 2'b10, 4'h2, 2'b10, 2'b01};
    tbl[2] = '{2'b11, 2'b11, 4'h1, 4'h2, 2'b11, 2'b01, 4'h1, 2'b01, 2'b10};
    tbl[3] = '{2'b11, 2'b11, 4'h1, 4'h2, 2'b11, 2'b10, 4'h2, 2'b10, 2'b01};
    // be=0 beat is still accepted
    tbl[4] = '{2'b01, 2'b11, 4'h0, 4'h2, 2'b00, 2'b01, 4'h0, 2'b00, 2'b10};
    // w1 opens a 3-beat burst; w0 is locked out, even while w1 idles a cycle
    tbl[5] = '{2'b11, 2'b01, 4'h3, 4'hC, 2'b01, 2'b10, 4'hC, 2'b01, 2'b00};
    tbl[6] = '{2'b01, 2'b01, 4'h3, 4'hC, 2'b10, 2'b00, 4'h0, 2'b10, 2'b01};
    tbl[7] = '{2'b11, 2'b01, 4'h3, 4'hC, 2'b00, 2'b10, 4'hC, 2'b00, 2'b10};
    tbl[8] = '{2'b11, 2'b11, 4'h3, 4'hC, 2'b00, 2'b10, 4'hC, 2'b00, 2'b00};
    // burst done: w0 is granted
    tbl[9] = '{2'b11, 2'b11, 4'h3, 4'hC, 2'b00, 2'b01, 4'h3, 2'b00, 2'b00};
  end

  localparam logic [127:0] DATA_A   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] EXP_A    = 128'hFFFFFFFF_89ABCDEF_FFFFFFFF_76543210;
  localparam logic [127:0] DATA_B   = 128'hBBBB0000_BBBB1111_BBBB2222_BBBB3333;
  localparam logic [127:0] DATA_C   = 128'hCCCC4444_CCCC5555_CCCC6666_CCCC7777;

  initial begin
    rst_n    = 1'b0;
    max_wait = 0;
    idle_inputs();
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    for (int n = 0; n < 2; n++) beats_left[n] = 0;

    // ---- outputs during reset, with every requester asserting valid ----
    repeat (2) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      w_valid[n] = 1'b1;
      r_valid[n] = 1'b1;
      w_be[n]    = 4'hF;
    end
    #1;
    check1("rst_w0_ready", w0_ready, 1'b0);
    check1("rst_w1_ready", w1_ready, 1'b0);
    check1("rst_r0_ready", r0_ready, 1'b0);
    check1("rst_r1_ready", r1_ready, 1'b0);
    check128("rst_ram_we", 128'(ram_we), 128'(4'b0000));
    check1("rst_ram_re", ram_re, 1'b0);
    check1("rst_r0_rvalid", r0_rvalid, 1'b0);
    check1("rst_r1_rvalid", r1_rvalid, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      for (int n = 0; n < 2; n++) begin
        w_valid[n] = tbl[i].wv[n];
        w_last[n]  = tbl[i].wl[n];
        w_addr[n]  = AB'(32 + 2 * i + n);
        w_data[n]  = {$urandom, $urandom, $urandom, $urandom};
        r_valid[n] = tbl[i].rv[n];
        r_addr[n]  = AB'(32 + 2 * i + n);
      end
      w_be[0] = tbl[i].be0;
      w_be[1] = tbl[i].be1;
      #1;
      check1("tbl_w0_ready", w0_ready, tbl[i].exp_wr[0]);
      check1("tbl_w1_ready", w1_ready, tbl[i].exp_wr[1]);
      check128("tbl_ram_we", 128'(ram_we), 128'(tbl[i].exp_we));
      check1("tbl_r0_ready", r0_ready, tbl[i].exp_rr[0]);
      check1("tbl_r1_ready", r1_ready, tbl[i].exp_rr[1]);
      check1("tbl_r0_rvalid", r0_rvalid, tbl[i].exp_rv[0]);
      check1("tbl_r1_rvalid", r1_rvalid, tbl[i].exp_rv[1]);
      run_cycle();
    end

    // ---- partial-lane write over an all-ones word, read back by r1 ----
    idle_inputs();
    w_valid[0] = 1'b1; w_addr[0] = AB'(5); w_be[0] = 4'hF;
    w_data[0]  = '1;   w_last[0] = 1'b1;
    run_cycle();
    w_be[0] = 4'b0101; w_data[0] = DATA_A;
    run_cycle();
    w_valid[0] = 1'b0;
    r_valid[1] = 1'b1; r_addr[1] = AB'(5);
    run_cycle();
    check1("lane_r1_rvalid", r1_rvalid, 1'b1);
    check1("lane_r0_rvalid", r0_rvalid, 1'b0);
    check128("lane_rdata", r1_rdata, EXP_A);
    r_valid[1] = 1'b0;

    // ---- same-cycle write and read of one address: read sees old data ----
    w_valid[0] = 1'b1; w_addr[0] = AB'(9); w_be[0] = 4'hF;
    w_data[0]  = DATA_B; w_last[0] = 1'b1;
    run_cycle();
    w_data[0]  = DATA_C;
    r_valid[0] = 1'b1; r_addr[0] = AB'(9);
    run_cycle();
    check128("rw_same_cycle_old", r0_rdata, DATA_B);
    w_valid[0] = 1'b0;
    run_cycle();
    check128("rw_next_cycle_new", r0_rdata, DATA_C);
    r_valid[0] = 1'b0;

    // ---- reset in the middle of a w0 burst, with a read response due ----
    w_valid[0] = 1'b1; w_addr[0] = AB'(20); w_be[0] = 4'hF; w_last[0] = 1'b0;
    r_valid[0] = 1'b1; r_addr[0] = AB'(5);
    run_cycle();
    check1("pre_rst_r0_rvalid", r0_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_r0_rvalid", r0_rvalid, 1'b0);
    check1("midrst_w0_ready", w0_ready, 1'b0);
    check128("midrst_ram_we", 128'(ram_we), 128'(4'b0000));
    check1("midrst_ram_re", ram_re, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check1("midrst_hold_r0_rvalid", r0_rvalid, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    // The lock is dropped: w1 alone is granted.
    // The read arbiter is back at its reset state: r0 wins the contention.
    w_valid[1] = 1'b1; w_addr[1] = AB'(21); w_be[1] = 4'h3; w_last[1] = 1'b1;
    r_valid[0] = 1'b1; r_addr[0] = AB'(9);
    r_valid[1] = 1'b1; r_addr[1] = AB'(5);
    #1;
    check1("post_rst_w1_ready", w1_ready, 1'b1);
    check1("post_rst_r0_wins", r0_ready, 1'b1);
    run_cycle();

    // ---- random traffic against the reference model ----
    idle_inputs();
    for (int n = 0; n < 2; n++) begin
      acc_w[n]      = 1'b0;
      acc_r[n]      = 1'b0;
      beats_left[n] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (acc_w[n]) w_valid[n] = 1'b0;
        if (!w_valid[n] && $urandom_range(0, 1) == 1) begin
          if (beats_left[n] == 0) beats_left[n] = $urandom_range(1, 4);
          w_valid[n] = 1'b1;
          w_addr[n]  = AB'($urandom_range(0, 15));
          w_be[n]    = 4'($urandom_range(0, 15));
          w_data[n]  = {$urandom, $urandom, $urandom, $urandom};
          w_last[n]  = (beats_left[n] == 1);
          beats_left[n]--;
        end
        if (acc_r[n]) r_valid[n] = 1'b0;
        if (!r_valid[n] && $urandom_range(0, 1) == 1) begin
          r_valid[n] = 1'b1;
          r_addr[n]  = AB'($urandom_range(0, 15));
        end
      end
      run_cycle();
    end
    // Let the last read response drain.
    idle_inputs();
    repeat (2) run_cycle();
    check1("max_write_wait_bounded", max_wait < 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nvme_buffer_arbiter.md
# nvme_buffer_arbiter

Two-requester arbiter for the NVMe data buffer RAM (32-bit-lane byte-enabled write port, registered read port, 128-bit data). It shares the write port between two writers with burst locking, and the read port between two readers with 1-cycle response routing. Arbitration is round-robin and independent on each port. It sits between the NVMe DMA engines (requester 0: PCIe completion path; requester 1: host AXI path) and the buffer RAM, with all RAM ports on a single clock.

## Interface
- ADDR_BITS, 8, RAM word address width.
- clk  in  1  sole clock; drives the RAM write and read clocks.
- rst_n  in  1  reset; asynchronous, active-low.
- wN_valid / wN_ready (N=0,1)  in/out  1  write request handshake; transfer occurs when both are high.
- wN_addr  in  ADDR_BITS  write word address.
- wN_be  in  4  32-bit lane enables; bit i covers data[32i+31:32i].
- wN_data  in  128  write data.
- wN_last  in  1  final beat of a write burst.
- rN_valid / rN_ready (N=0,1)  in/out  1  read request handshake.
- rN_addr  in  ADDR_BITS  read word address.
- rN_rvalid  out  1  read data valid; no backpressure.
- rN_rdata  out  128  read data.
- ram_we  out  4  RAM lane write enables.
- ram_waddr  out  ADDR_BITS  RAM write address.
- ram_din  out  128  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  ADDR_BITS  RAM read address.
- ram_dout  in  128  RAM read data, registered in the RAM, valid the cycle after ram_re.

## Operation
- Write FSM states: IDLE, LOCK0, LOCK1. There is also a register wlast_gnt (last requester granted a write).
  - IDLE: if exactly one wN_valid, grant N. If both are valid, grant the requester that is not wlast_gnt.
  - A granted beat with wN_last=0 moves to LOCKN. A beat with wN_last=1 stays in IDLE. wlast_gnt updates to N on every granted beat.
  - LOCKN: only requester N is granted (wN_ready = wN_valid); the other requester's ready is 0. A beat with wN_last=1 returns to IDLE. While in LOCKN, invalid beats from N hold the lock indefinitely.
- wN_ready is combinational from the state, valids and wlast_gnt. It never depends on wN_ready of the other requester.
- On an accepted beat: ram_we = wN_be, ram_waddr = wN_addr, ram_din = wN_data. Otherwise ram_we = 4'b0000.
  - be = 0 is still accepted and counts as a beat, including its last bit.
- Read arbitration: single-beat and round-robin with register rlast_gnt, using the same rule as IDLE. It never locks.
- On an accepted read: ram_re = 1, ram_raddr = rN_addr. A tag register captures {valid, N}.
- The next cycle: rN_rvalid = 1 for the tagged N only, and rN_rdata = ram_dout. rN_rdata is don't-care when rvalid=0 (drive ram_dout to both).
- Read and write to the same address in the same cycle: no forwarding. The read returns pre-write data.
- Read and write ports are fully independent. Both may accept in the same cycle.

## Timing
- Reset values: state = IDLE, wlast_gnt = 1, rlast_gnt = 1 (so requester 0 wins the first contention on each port), tag valid = 0.
  - During reset all rN_rvalid = 0, ram_we = 0, ram_re = 0, and all ready outputs = 0.
- Write latency: zero cycles from handshake to RAM write enable. The RAM commits at the same clk edge.
- Read latency: the request handshake at cycle t gives rN_rvalid at t+1. Throughput is one read per cycle on the port; back-to-back grants are allowed.
- Reset asserted mid-burst: the FSM returns to IDLE asynchronously and the lock is dropped. An in-flight read response is discarded (rvalid stays 0).
- Requesters must hold valid/addr/data stable until accepted. The arbiter may withdraw ready when the other requester wins.

## Test plan
- Reset release, w0 and w1 both valid single-beat (last=1) for 4 cycles -> grants 0,1,0,1; ram_we follows each be. r0 and r1 both valid -> grants 0,1,0,1.
- w1 issues a 3-beat burst (last on beat 3) while w0 is valid throughout -> w1 gets 3 consecutive beats, w0_ready=0 during the lock, w0 granted on cycle 4.
- Write addr 5 data A, be=4'b0101, over a previous all-ones word; then read addr 5 -> rdata = {32'hFFFFFFFF, A[95:64], 32'hFFFFFFFF, A[31:0]} one cycle after the read handshake, rvalid on the requester that read only.
- Same-cycle write to addr 9 and read of addr 9 (old value B, new C) -> read returns B; a read in the following cycle returns C.
- Assert rst_n=0 in the middle of a w0 burst with a read in flight -> no rvalid after the reset edge. After release, state is IDLE and contention is won by requester 0.
- Random traffic on all four requesters for 10k cycles against a reference memory model -> all read data matches, no burst interleaving, and no requester waits more than one competing burst.
